// File: rtl/led_pkg.sv
// Shared LED-bank types and helpers.
// Also used by blink-style blocks to derive their period constants.
package led_pkg;

  localparam int LED_W = 8;

  typedef enum logic {
    IDLE,
    OWN
  } state_t;

  function automatic int ms_to_cycles(
    input int freq,
    input int ms
  );
    return (freq / 1000) * ms;
  endfunction

endpackage

// File: rtl/led_slot_arbiter_rr_pick.sv
// Combinational round-robin picker.
// Scans rr_ptr+1, rr_ptr+2, ... modulo N.
module led_slot_arbiter_rr_pick #(
  parameter int N = 4
) (
  input  logic [N-1:0] req,
  input  logic [2:0]   rr_ptr,
  output logic         valid,
  output logic [2:0]   winner
);

  int tgt;

  // Walk from lowest to highest priority so the last hit wins.
  always_comb begin
    valid  = 1'b0;
    winner = '0;
    tgt    = 0;
    for (int i = N; i >= 1; i--) begin
      tgt = (int'(rr_ptr) + i) % N;
      for (int j = 0; j < N; j++) begin
        if (req[j] && (j == tgt)) begin
          valid  = 1'b1;
          winner = 3'(j);
        end
      end
    end
  end

endmodule

// File: rtl/led_slot_arbiter.sv
// Time-slot round-robin owner of the shared 8-LED bank.
// One owner per slot; rotates on expiry, releases on req drop.
module led_slot_arbiter
  import led_pkg::*;
#(
  parameter int              CLK_FREQ     = 25_000_000,
  parameter int              SLOT_MS      = 500,
  parameter int              N_REQ        = 4,
  parameter logic [LED_W-1:0] IDLE_PATTERN = 8'h00
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [N_REQ-1:0]       req,
  input  logic [LED_W*N_REQ-1:0] pattern,
  output logic [N_REQ-1:0]       grant,
  output logic [2:0]             owner_id,
  output logic                   slot_end,
  output logic [LED_W-1:0]       leds
);

  localparam int SLOT_CYCLES = ms_to_cycles(CLK_FREQ, SLOT_MS);
  localparam int CNT_W       = $clog2(SLOT_CYCLES);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SLOT_CYCLES - 1);

  state_t             state, state_n;
  logic [N_REQ-1:0]   grant_n;
  logic [2:0]         owner_n;
  logic [2:0]         rr_ptr, rr_n;
  logic [CNT_W-1:0]   cnt, cnt_n;
  logic               slot_end_n;
  logic [LED_W-1:0]   leds_n;

  logic               pick_valid;
  logic [2:0]         pick_idx;
  logic               own_req;
  logic [LED_W-1:0]   own_pat;
  logic [N_REQ-1:0]   pick_onehot;

  led_slot_arbiter_rr_pick #(
    .N(N_REQ)
  ) u_pick (
    .req    (req),
    .rr_ptr (rr_ptr),
    .valid  (pick_valid),
    .winner (pick_idx)
  );

  always_comb begin
    own_req     = 1'b0;
    own_pat     = IDLE_PATTERN;
    pick_onehot = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (owner_id == 3'(i)) begin
        own_req = req[i];
        own_pat = pattern[LED_W*i +: LED_W];
      end
      pick_onehot[i] = (pick_idx == 3'(i));
    end
  end

  always_comb begin
    state_n    = state;
    grant_n    = grant;
    owner_n    = owner_id;
    rr_n       = rr_ptr;
    cnt_n      = cnt;
    slot_end_n = 1'b0;
    leds_n     = leds;
    unique case (state)
      IDLE: begin
        leds_n = IDLE_PATTERN;
        if (pick_valid) begin
          state_n = OWN;
          grant_n = pick_onehot;
          owner_n = pick_idx;
          rr_n    = pick_idx;
          cnt_n   = '0;
        end
      end
      OWN: begin
        leds_n = own_pat;
        if (!own_req) begin
          // Release wins over a coincident expiry.
          state_n    = IDLE;
          grant_n    = '0;
          owner_n    = '0;
          cnt_n      = '0;
          slot_end_n = 1'b1;
          leds_n     = IDLE_PATTERN;
        end else if (cnt == CNT_LAST) begin
          grant_n    = pick_onehot;
          owner_n    = pick_idx;
          rr_n       = pick_idx;
          cnt_n      = '0;
          slot_end_n = 1'b1;
        end else begin
          cnt_n = cnt + CNT_W'(1);
        end
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state    <= IDLE;
      grant    <= '0;
      owner_id <= '0;
      rr_ptr   <= 3'(N_REQ - 1);
      cnt      <= '0;
      slot_end <= 1'b0;
      leds     <= IDLE_PATTERN;
    end else begin
      state    <= state_n;
      grant    <= grant_n;
      owner_id <= owner_n;
      rr_ptr   <= rr_n;
      cnt      <= cnt_n;
      slot_end <= slot_end_n;
      leds     <= leds_n;
    end
  end

endmodule

// File: tb/tb_led_slot_arbiter.sv
// Directed bench for led_slot_arbiter.
// SLOT_CYCLES=10, N_REQ=4; inputs driven and outputs sampled on negedge.
module tb_led_slot_arbiter;

  logic        clk;
  logic        rst_n;
  logic [3:0]  req;
  logic [31:0] pattern;
  logic [3:0]  grant;
  logic [2:0]  owner_id;
  logic        slot_end;
  logic [7:0]  leds;

  int checks;
  int failures;

  led_slot_arbiter #(
    .CLK_FREQ     (1000),
    .SLOT_MS      (10),
    .N_REQ        (4),
    .IDLE_PATTERN (8'h00)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .req      (req),
    .pattern  (pattern),
    .grant    (grant),
    .owner_id (owner_id),
    .slot_end (slot_end),
    .leds     (leds)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [7:0] obs,
                     input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic chk_out(input string tag, input logic [3:0] g,
                         input logic [2:0] o, input logic se);
    chk({tag, ".grant"}, {4'b0, grant}, {4'b0, g});
    chk({tag, ".owner"}, {5'b0, owner_id}, {5'b0, o});
    chk({tag, ".slot_end"}, {7'b0, slot_end}, {7'b0, se});
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    rst_n    = 1'b0;
    req      = 4'b1111;
    pattern  = {8'hCC, 8'h55, 8'h33, 8'hAA};

    step(2);
    chk_out("rst", 4'b0000, 3'd0, 1'b0);
    chk("rst.leds", leds, 8'h00);

    rst_n = 1'b1;
    step(1);
    chk_out("first", 4'b0001, 3'd0, 1'b0);
    chk("first.leds", leds, 8'h00);
    step(1);
    chk("first.leds_own", leds, 8'hAA);

    // Two requesters alternate with no idle gap.
    req = 4'b0101;
    step(8);
    chk_out("rr.pre", 4'b0001, 3'd0, 1'b0);
    step(1);
    chk_out("rr.sw1", 4'b0100, 3'd2, 1'b1);
    chk("rr.sw1.leds", leds, 8'hAA);
    step(1);
    chk("rr.sw1.leds2", leds, 8'h55);
    chk("rr.sw1.se_low", {7'b0, slot_end}, 8'h00);
    step(8);
    chk_out("rr.pre2", 4'b0100, 3'd2, 1'b0);
    step(1);
    chk_out("rr.sw2", 4'b0001, 3'd0, 1'b1);

    // Single requester re-granted each slot.
    req = 4'b0010;
    step(1);
    chk_out("solo.rel", 4'b0000, 3'd0, 1'b1);
    chk("solo.rel.leds", leds, 8'h00);
    step(1);
    chk_out("solo.grant", 4'b0010, 3'd1, 1'b0);
    step(9);
    chk_out("solo.pre", 4'b0010, 3'd1, 1'b0);
    step(1);
    chk_out("solo.regrant", 4'b0010, 3'd1, 1'b1);
    chk("solo.leds", leds, 8'h33);
    step(1);
    chk_out("solo.post", 4'b0010, 3'd1, 1'b0);

    // Hand bank to requester 0, then drop it mid-slot.
    req = 4'b0001;
    step(1);
    chk_out("er.rel1", 4'b0000, 3'd0, 1'b1);
    step(1);
    chk_out("er.own0", 4'b0001, 3'd0, 1'b0);
    req = 4'b1001;
    step(4);
    req = 4'b1000;
    step(1);
    chk_out("er.idle", 4'b0000, 3'd0, 1'b1);
    chk("er.idle.leds", leds, 8'h00);
    step(1);
    chk_out("er.own3", 4'b1000, 3'd3, 1'b0);
    chk("er.own3.leds", leds, 8'h00);
    step(1);
    chk("er.own3.leds2", leds, 8'hCC);
    step(8);
    chk_out("er.full", 4'b1000, 3'd3, 1'b0);
    step(1);
    chk_out("er.regrant", 4'b1000, 3'd3, 1'b1);

    // Owner drops exactly in its expiry cycle.
    req = 4'b1010;
    step(9);
    chk_out("ex.pre", 4'b1000, 3'd3, 1'b0);
    req = 4'b0010;
    step(1);
    chk_out("ex.rel", 4'b0000, 3'd0, 1'b1);
    chk("ex.rel.leds", leds, 8'h00);
    step(1);
    chk_out("ex.own1", 4'b0010, 3'd1, 1'b0);

    // Reset mid-slot with owner 2.
    req = 4'b0100;
    step(1);
    chk_out("mr.rel", 4'b0000, 3'd0, 1'b1);
    step(1);
    chk_out("mr.own2", 4'b0100, 3'd2, 1'b0);
    step(3);
    chk("mr.leds", leds, 8'h55);
    rst_n = 1'b0;
    req   = 4'b1001;
    step(1);
    chk_out("mr.rst", 4'b0000, 3'd0, 1'b0);
    chk("mr.rst.leds", leds, 8'h00);
    step(1);
    rst_n = 1'b1;
    step(1);
    chk_out("mr.after", 4'b0001, 3'd0, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
